// File: rtl/alu_instr_sequencer_if.sv
// alu_instr_sequencer_if: control/handshake bundle between the step sequencer and the single-bus datapath.
interface alu_instr_sequencer_if #(parameter int OPC_W = 5, parameter int NUM_REGS = 16);
  logic run;
  logic [31:0] ir;
  logic mem_ack;
  logic PCout, Zlowout, ZHighout, MDRout;
  logic MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic IncPC, Read;
  logic [NUM_REGS-1:0] reg_in, reg_out;
  logic [OPC_W-1:0] alu_op;
  logic done, illegal, halted;
  logic [3:0] state;
  modport master (
    input run, ir, mem_ack,
    output PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
    output IncPC, Read, reg_in, reg_out, alu_op, done, illegal, halted, state
  );
  modport slave (
    output run, ir, mem_ack,
    input PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
    input IncPC, Read, reg_in, reg_out, alu_op, done, illegal, halted, state
  );
endinterface

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: fetch/decode/execute step FSM driving single-bus datapath strobes.
// Define MULDIV_EN to enable the two-register mul/div opcodes (RTYPE_MAX, RTYPE_MAX+1) with a T6 step.
module alu_instr_sequencer #(
  parameter int OPC_W     = 5,
  parameter int REG_SEL_W = 4,
  parameter int NUM_REGS  = 16,
  parameter int RTYPE_MAX = 12,
  parameter int HALT_OPC  = 27
) (
  input logic Clock,
  input logic Clear,
  alu_instr_sequencer_if.master bus
);
`ifdef MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  typedef enum logic [3:0] {IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, HALT} state_t;
  state_t st, nx;
  logic [OPC_W-1:0] opc_d, opc_q;
  logic [REG_SEL_W-1:0] ra_d, rb_d, rc_d, ra_q, rb_q, rc_q;
  logic rt_d, md_d, halt_d, md_q;
  function automatic logic ok(input logic [REG_SEL_W-1:0] s);
    return int'(s) < NUM_REGS;
  endfunction
  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] s);
    return ok(s) ? NUM_REGS'(1) << s : '0;
  endfunction
  assign opc_d  = bus.ir[31 -: OPC_W];
  assign ra_d   = bus.ir[31-OPC_W -: REG_SEL_W];
  assign rb_d   = bus.ir[31-OPC_W-REG_SEL_W -: REG_SEL_W];
  assign rc_d   = bus.ir[31-OPC_W-2*REG_SEL_W -: REG_SEL_W];
  assign rt_d   = int'(opc_d) < RTYPE_MAX && ok(ra_d) && ok(rb_d) && ok(rc_d);
  assign md_d   = MD && (int'(opc_d) == RTYPE_MAX || int'(opc_d) == RTYPE_MAX + 1) && ok(ra_d) && ok(rb_d);
  assign halt_d = int'(opc_d) == HALT_OPC;
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      st    <= IDLE;
      opc_q <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      md_q  <= 1'b0;
    end else begin
      st <= nx;
      if (st == T3) begin
        opc_q <= opc_d;
        ra_q  <= ra_d;
        rb_q  <= rb_d;
        rc_q  <= rc_d;
        md_q  <= md_d;
      end
    end
  end
  // Strobes decode from the present state only; T3 reads ir directly since the fields latch at its end.
  always_comb begin
    nx           = st;
    bus.PCout    = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.ZHighout = 1'b0;
    bus.MDRout   = 1'b0;
    bus.MARin    = 1'b0;
    bus.PCin     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.reg_in   = '0;
    bus.reg_out  = '0;
    bus.alu_op   = '0;
    bus.done     = 1'b0;
    bus.illegal  = 1'b0;
    bus.halted   = 1'b0;
    case (st)
      IDLE: nx = bus.run ? T0 : IDLE;
      T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
        nx        = T1;
      end
      T1, T1W: begin
        bus.Zlowout = st == T1;
        bus.PCin    = st == T1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        nx          = bus.mem_ack ? T2 : T1W;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        nx         = T3;
      end
      T3: begin
        bus.reg_out = rt_d ? onehot(rb_d) : md_d ? onehot(ra_d) : '0;
        bus.Yin     = rt_d || md_d;
        bus.illegal = !(rt_d || md_d || halt_d);
        bus.done    = bus.illegal;
        nx          = (rt_d || md_d) ? T4 : halt_d ? HALT : bus.run ? T0 : IDLE;
      end
      T4: begin
        bus.reg_out = onehot(md_q ? rb_q : rc_q);
        bus.alu_op  = opc_q;
        bus.Zin     = 1'b1;
        nx          = T5;
      end
      T5: begin
        bus.Zlowout = 1'b1;
        bus.reg_in  = md_q ? '0 : onehot(ra_q);
        bus.LOin    = MD && md_q;
        bus.done    = !md_q;
        nx          = md_q ? T6 : bus.run ? T0 : IDLE;
      end
      T6: begin
        bus.ZHighout = MD;
        bus.HIin     = MD;
        bus.done     = MD;
        nx           = bus.run ? T0 : IDLE;
      end
      HALT: bus.halted = 1'b1;
      default: nx = IDLE;
    endcase
  end
  assign bus.state = st;
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer: directed step sequence with an expected-cycle queue for alu_instr_sequencer.
module tb_alu_instr_sequencer;
  localparam logic [3:0] S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T1W = 4'd3, S_T2 = 4'd4;
  localparam logic [3:0] S_T3 = 4'd5, S_T4 = 4'd6, S_T5 = 4'd7, S_T6 = 4'd8, S_HALT = 4'd9;
  localparam logic [13:0] PCOUT = 14'h2000, ZLOW = 14'h1000, ZHIGH = 14'h0800, MDROUT = 14'h0400;
  localparam logic [13:0] MARIN = 14'h0200, PCIN = 14'h0100, MDRIN = 14'h0080, IRIN = 14'h0040;
  localparam logic [13:0] YIN = 14'h0020, ZIN = 14'h0010, HIIN = 14'h0008, LOIN = 14'h0004;
  localparam logic [13:0] INCPC = 14'h0002, READ = 14'h0001;
  typedef struct packed {
    logic [3:0]  st;
    logic [13:0] stb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  op;
    logic        d;
    logic        il;
    logic        h;
  } rec_t;
  logic Clock = 1'b0;
  logic Clear;
  int vectors = 0;
  int miscompares = 0;
  rec_t q[$];
  alu_instr_sequencer_if #(.OPC_W(5), .NUM_REGS(16)) bus ();
  alu_instr_sequencer #(.OPC_W(5), .REG_SEL_W(4), .NUM_REGS(16), .RTYPE_MAX(12), .HALT_OPC(27)) dut (
    .Clock(Clock),
    .Clear(Clear),
    .bus(bus)
  );
  always #5 Clock = ~Clock;
  task automatic push(input logic [3:0] s, input logic [13:0] b, input logic [15:0] ri, input logic [15:0] ro,
                      input logic [4:0] op, input logic d, input logic il, input logic h);
    rec_t r;
    r = '{st: s, stb: b, rin: ri, rout: ro, op: op, d: d, il: il, h: h};
    q.push_back(r);
  endtask
  task automatic push_fetch();
    push(S_T0, PCOUT | MARIN | INCPC | ZIN, '0, '0, '0, 0, 0, 0);
    push(S_T1, ZLOW | PCIN | READ | MDRIN, '0, '0, '0, 0, 0, 0);
    push(S_T2, MDROUT | IRIN, '0, '0, '0, 0, 0, 0);
  endtask
  // mask bit i drives the input low during the transition that produces queued entry i
  task automatic drain(input string tag, input int ack_lo, input int clr_lo, input int run_lo);
    int i;
    rec_t e, o;
    i = 0;
    while (q.size() > 0) begin
      bus.mem_ack = !ack_lo[i];
      Clear       = !clr_lo[i];
      bus.run     = !run_lo[i];
      @(negedge Clock);
      e = q.pop_front();
      o = '{st: bus.state,
            stb: {bus.PCout, bus.Zlowout, bus.ZHighout, bus.MDRout, bus.MARin, bus.PCin, bus.MDRin,
                  bus.IRin, bus.Yin, bus.Zin, bus.HIin, bus.LOin, bus.IncPC, bus.Read},
            rin: bus.reg_in, rout: bus.reg_out, op: bus.alu_op,
            d: bus.done, il: bus.illegal, h: bus.halted};
      vectors++;
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s step %0d: observed %h expected %h", tag, i, o, e);
      end
      i++;
    end
  endtask
  initial begin
    Clear = 1'b0;
    bus.run = 1'b1;
    bus.mem_ack = 1'b1;
    bus.ir = 32'h4A920000;
    push(S_IDLE, '0, '0, '0, '0, 0, 0, 0);
    push(S_IDLE, '0, '0, '0, '0, 0, 0, 0);
    drain("reset", 0, 'h3, 0);
    push_fetch();
    push(S_T3, YIN, '0, 16'h0004, '0, 0, 0, 0);
    push(S_T4, ZIN, '0, 16'h0010, 5'd9, 0, 0, 0);
    push(S_T5, ZLOW, 16'h0020, '0, '0, 1, 0, 0);
    drain("rtype", 0, 0, 0);
    push(S_T0, PCOUT | MARIN | INCPC | ZIN, '0, '0, '0, 0, 0, 0);
    push(S_T1, ZLOW | PCIN | READ | MDRIN, '0, '0, '0, 0, 0, 0);
    for (int k = 0; k < 3; k++) push(S_T1W, READ | MDRIN, '0, '0, '0, 0, 0, 0);
    push(S_T2, MDROUT | IRIN, '0, '0, '0, 0, 0, 0);
    push(S_T3, YIN, '0, 16'h0004, '0, 0, 0, 0);
    push(S_T4, ZIN, '0, 16'h0010, 5'd9, 0, 0, 0);
    push(S_T5, ZLOW, 16'h0020, '0, '0, 1, 0, 0);
    drain("memwait", 'h1C, 0, 0);
    bus.ir = 32'hA0000000;
    push_fetch();
    push(S_T3, '0, '0, '0, '0, 1, 1, 0);
    push(S_T0, PCOUT | MARIN | INCPC | ZIN, '0, '0, '0, 0, 0, 0);
    drain("illegal", 0, 0, 0);
    bus.ir = 32'h4A920000;
    push(S_T1, ZLOW | PCIN | READ | MDRIN, '0, '0, '0, 0, 0, 0);
    push(S_T2, MDROUT | IRIN, '0, '0, '0, 0, 0, 0);
    push(S_T3, YIN, '0, 16'h0004, '0, 0, 0, 0);
    push(S_T4, ZIN, '0, 16'h0010, 5'd9, 0, 0, 0);
    push(S_IDLE, '0, '0, '0, '0, 0, 0, 0);
    drain("clear_t4", 0, 'h10, 0);
    bus.ir = {5'd3, 4'd7, 4'd7, 4'd7, 15'd0};
    push_fetch();
    push(S_T3, YIN, '0, 16'h0080, '0, 0, 0, 0);
    push(S_T4, ZIN, '0, 16'h0080, 5'd3, 0, 0, 0);
    push(S_T5, ZLOW, 16'h0080, '0, '0, 1, 0, 0);
    push(S_IDLE, '0, '0, '0, '0, 0, 0, 0);
    drain("same_regs", 0, 0, 'h40);
    bus.ir = 32'hD8000000;
    push_fetch();
    push(S_T3, '0, '0, '0, '0, 0, 0, 0);
    for (int k = 0; k < 11; k++) push(S_HALT, '0, '0, '0, '0, 0, 0, 1);
    drain("halt", 0, 0, 'h5540);
    push(S_IDLE, '0, '0, '0, '0, 0, 0, 0);
    push(S_IDLE, '0, '0, '0, '0, 0, 0, 0);
    drain("halt_clear", 0, 'h1, 'h2);
    bus.ir = {5'd12, 4'd3, 4'd7, 4'd0, 15'd0};
    push_fetch();
`ifdef MULDIV_EN
    push(S_T3, YIN, '0, 16'h0008, '0, 0, 0, 0);
    push(S_T4, ZIN, '0, 16'h0080, 5'd12, 0, 0, 0);
    push(S_T5, ZLOW | LOIN, '0, '0, '0, 0, 0, 0);
    push(S_T6, ZHIGH | HIIN, '0, '0, '0, 1, 0, 0);
`else
    push(S_T3, '0, '0, '0, '0, 1, 1, 0);
`endif
    push(S_T0, PCOUT | MARIN | INCPC | ZIN, '0, '0, '0, 0, 0, 0);
    drain("muldiv", 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
